// File: rtl/instruction_sequencer_pkg.sv
// seq_pkg: sequencer state encoding and opcode classes shared by the sequencer files
package seq_pkg;
    typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WRITE, DONE} state_t;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LMM = 4'h1;
endpackage

// File: rtl/instruction_sequencer_debouncer.sv
// key_debouncer: synchronizes an active-low key, debounces it and pulses once per accepted press
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic          r_s1, r_s2, r_level, r_armed;
    logic [1:0]    r_warm;
    logic [CW-1:0] r_cnt;
    logic          w_flip;
    assign w_flip = (r_s2 != r_level) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    // Stable-sample counter; a key already low when reset drops must be seen released before it can pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_level <= 1'b1;
            r_armed <= 1'b0;
            r_warm  <= 2'd0;
            r_cnt   <= '0;
            o_press <= 1'b0;
        end else begin
            r_s1    <= i_key;
            r_s2    <= r_s1;
            r_warm  <= (r_warm == 2'd2) ? r_warm : r_warm + 2'd1;
            r_armed <= r_armed | ((r_warm == 2'd2) && r_s2);
            r_cnt   <= (r_s2 == r_level || w_flip) ? '0 : r_cnt + CW'(1);
            r_level <= w_flip ? r_s2 : r_level;
            o_press <= w_flip && !r_s2 && r_armed;
        end
    end
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: runs one latched instruction per execute press through decode, read, ALU and write-back
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       KEY,
    input  logic [3:0]       codop,
    input  logic [3:0]       addA,
    input  logic [3:0]       addB_LMM,
    input  logic [3:0]       addC,
    input  logic             alu_done,
    output logic [3:0]       op_q,
    output logic [3:0]       ra_q,
    output logic [3:0]       rb_q,
    output logic [3:0]       rc_q,
    output logic             rf_rd_en,
    output logic             alu_start,
    output logic             imm_sel,
    output logic             rf_wr_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_count
);
    state_t r_state, w_next;
    logic   w_exec, w_abort, r_in_exec, w_unused_keys;
    assign w_unused_keys = ^KEY[3:2];
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exec_key (
        .clk(clk), .rst(rst), .i_key(KEY[0]), .o_press(w_exec)
    );
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_abort_key (
        .clk(clk), .rst(rst), .i_key(KEY[1]), .o_press(w_abort)
    );
    // Next state and strobes; an abort while busy returns to IDLE and suppresses start/write/done
    always_comb begin
        w_next    = r_state;
        rf_rd_en  = 1'b0;
        alu_start = 1'b0;
        rf_wr_en  = 1'b0;
        done      = 1'b0;
        busy      = r_state != IDLE;
        case (r_state)
            IDLE:    w_next = w_exec ? DECODE : IDLE;
            DECODE:  w_next = (op_q == OP_NOP) ? DONE : (op_q == OP_LMM) ? WRITE : READ;
            READ: begin
                rf_rd_en = 1'b1;
                w_next   = EXEC;
            end
            EXEC: begin
                alu_start = !r_in_exec;
                w_next    = alu_done ? WRITE : EXEC;
            end
            WRITE: begin
                rf_wr_en = 1'b1;
                w_next   = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (busy && w_abort) begin
            w_next    = IDLE;
            alu_start = 1'b0;
            rf_wr_en  = 1'b0;
            done      = 1'b0;
        end
    end
    // State register; r_in_exec marks EXEC cycles after the first so alu_start is a single pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_in_exec <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_in_exec <= r_state == EXEC;
        end
    end
    // Instruction fields and write-back source are captured only on the accepted execute press
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= 4'h0;
            ra_q    <= 4'h0;
            rb_q    <= 4'h0;
            rc_q    <= 4'h0;
            imm_sel <= 1'b0;
        end else if (r_state == IDLE && w_exec) begin
            op_q    <= codop;
            ra_q    <= addA;
            rb_q    <= addB_LMM;
            rc_q    <= addC;
            imm_sel <= codop == OP_LMM;
        end
    end
    // Completed-instruction counter, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) instr_count <= '0;
        else if (done) instr_count <= instr_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: scoreboard bench; stimulus queues expected instruction results, a monitor checks them
module tb_instruction_sequencer;
    localparam int DB = 4;
    logic       clk = 1'b0, rst = 1'b1, alu_done = 1'b0;
    logic [3:0] KEY = 4'hF, codop = 4'h0, addA = 4'h0, addB_LMM = 4'h0, addC = 4'h0;
    logic [3:0] op_q, ra_q, rb_q, rc_q;
    logic       rf_rd_en, alu_start, imm_sel, rf_wr_en, busy, done;
    logic [7:0] instr_count;

    instruction_sequencer #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .KEY(KEY), .codop(codop), .addA(addA), .addB_LMM(addB_LMM),
        .addC(addC), .alu_done(alu_done), .op_q(op_q), .ra_q(ra_q), .rb_q(rb_q), .rc_q(rc_q),
        .rf_rd_en(rf_rd_en), .alu_start(alu_start), .imm_sel(imm_sel), .rf_wr_en(rf_wr_en),
        .busy(busy), .done(done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int op, ra, rb, rc, imm, rd, st, wr, dn, cnt, lat;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_pass = 0, cyc = 0, rises = 0, alu_k = 0, t_rise = 0, t_fall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic go(input string nm, input int op, input int ra, input int rb, input int rc,
                      input int imm, input int rd, input int st, input int wr, input int dn,
                      input int cnt, input int lat);
        exp_t e;
        codop = op[3:0]; addA = ra[3:0]; addB_LMM = rb[3:0]; addC = rc[3:0];
        e.nm = nm; e.op = op; e.ra = ra; e.rb = rb; e.rc = rc; e.imm = imm;
        e.rd = rd; e.st = st; e.wr = wr; e.dn = dn; e.cnt = cnt; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic key_tap(input int k, input int hold);
        @(posedge clk); #1 KEY[k] = 1'b0; t_fall = cyc;
        repeat (hold) @(posedge clk);
        #1 KEY[k] = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic settle();
        repeat (DB + 4) @(posedge clk);
    endtask

    // ALU model: raise alu_done for one cycle on the alu_k-th EXEC cycle (alu_k = 0: never)
    initial begin
        forever begin
            @(negedge clk);
            if (alu_start && alu_k > 0) begin
                repeat (alu_k - 1) @(posedge clk);
                #1 alu_done = 1'b1;
                @(posedge clk);
                #1 alu_done = 1'b0;
            end
        end
    end

    // Monitor: one busy interval is one instruction; compare it against the next queued expectation
    initial begin
        logic pb = 1'b0;
        int rd = 0, st = 0, wr = 0, dn = 0, imm = 0, td = 0, fo = 0, fa = 0, fb = 0, fc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy && !pb) begin
                rises++; t_rise = cyc; rd = 0; st = 0; wr = 0; dn = 0; imm = 0;
            end
            if (busy) begin
                rd += int'(rf_rd_en); st += int'(alu_start); wr += int'(rf_wr_en); dn += int'(done);
                if (rf_wr_en) imm = int'(imm_sel);
                if (done) td = cyc;
                fo = int'(op_q); fa = int'(ra_q); fb = int'(rb_q); fc = int'(rc_q);
            end
            if (!busy && pb) begin
                if (sb.size() == 0) chk("unexpected_instr_queue_size", sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    chk({e.nm, ".op_q"}, fo, e.op);
                    chk({e.nm, ".ra_q"}, fa, e.ra);
                    chk({e.nm, ".rb_q"}, fb, e.rb);
                    chk({e.nm, ".rc_q"}, fc, e.rc);
                    chk({e.nm, ".rf_rd_en_cycles"}, rd, e.rd);
                    chk({e.nm, ".alu_start_cycles"}, st, e.st);
                    chk({e.nm, ".rf_wr_en_cycles"}, wr, e.wr);
                    chk({e.nm, ".done_cycles"}, dn, e.dn);
                    chk({e.nm, ".imm_sel_at_write"}, imm, e.imm);
                    chk({e.nm, ".instr_count"}, int'(instr_count), e.cnt);
                    if (e.lat >= 0) chk({e.nm, ".pulse_to_done"}, td - (t_rise - 1), e.lat);
                end
            end
            pb = busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, %0d checks made", n_chk);
        $fatal(1);
    end

    initial begin
        int r0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.op_q", int'(op_q), 0);
        chk("reset.ra_q", int'(ra_q), 0);
        chk("reset.rb_q", int'(rb_q), 0);
        chk("reset.rc_q", int'(rc_q), 0);
        chk("reset.rf_rd_en", int'(rf_rd_en), 0);
        chk("reset.alu_start", int'(alu_start), 0);
        chk("reset.imm_sel", int'(imm_sel), 0);
        chk("reset.rf_wr_en", int'(rf_wr_en), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.instr_count", int'(instr_count), 0);
        settle();
        r0 = rises;
        key_tap(0, 3);
        repeat (12) @(posedge clk);
        chk("bounce_no_start", rises - r0, 0);
        chk("bounce_busy", int'(busy), 0);

        go("lmm", 1, 7, 10, 3, 1, 0, 0, 1, 1, 1, 3);
        key_tap(0, 10);
        r0 = t_fall;
        wait_idle();
        chk("fall_to_busy", t_rise - r0, DB + 3);
        settle();

        alu_k = 3;
        go("alu_k3", 5, 2, 6, 9, 0, 1, 1, 1, 1, 2, 7);
        key_tap(0, 10);
        codop = 4'hF; addA = 4'hF; addB_LMM = 4'h0; addC = 4'h0;
        wait_idle();
        settle();

        alu_k = 1;
        go("alu_k1", 2, 1, 14, 12, 0, 1, 1, 1, 1, 3, 5);
        key_tap(0, 10);
        wait_idle();
        settle();

        go("nop", 0, 4, 4, 4, 0, 0, 0, 0, 1, 4, 2);
        key_tap(0, 10);
        wait_idle();
        settle();

        alu_k = 30;
        r0 = rises;
        go("drop", 8, 3, 4, 5, 0, 1, 1, 1, 1, 5, 34);
        key_tap(0, 10);
        settle();
        key_tap(0, 10);
        wait_idle();
        settle();
        chk("drop_single_start", rises - r0, 1);

        alu_k = 0;
        go("abort", 3, 1, 2, 4, 0, 1, 1, 0, 0, 5, -1);
        key_tap(0, 10);
        key_tap(1, 10);
        wait_idle();
        settle();

        go("rst_exec", 6, 5, 11, 13, 0, 1, 1, 0, 0, 0, -1);
        key_tap(0, 10);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_exec.out_op_q", int'(op_q), 0);
        chk("rst_exec.out_rb_q", int'(rb_q), 0);
        chk("rst_exec.out_rc_q", int'(rc_q), 0);
        chk("rst_exec.out_busy", int'(busy), 0);
        chk("rst_exec.out_rf_wr_en", int'(rf_wr_en), 0);
        chk("rst_exec.out_alu_start", int'(alu_start), 0);
        chk("rst_exec.out_instr_count", int'(instr_count), 0);
        rst = 1'b0;
        settle();

        for (int i = 0; i < 256; i++) begin
            go("wrap", 0, 0, 0, 0, 0, 0, 0, 0, 1, (i + 1) % 256, 2);
            key_tap(0, 10);
            wait_idle();
            settle();
        end
        chk("wrap_count", int'(instr_count), 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Multi-cycle controller between the front-panel switch/key inputs and the CPU datapath. It debounces the board push-buttons, latches the 16-bit instruction fields on a confirmed "execute" press, and steps the datapath through decode, register read, ALU execute and write-back with explicit enables and an ALU start/done handshake. It sits directly downstream of the switch field decoder and drives the register file and ALU control inputs. It runs one instruction per key press.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized samples required to accept a key level change (≥2).
- CNT_W, 8: width of the completed-instruction counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset: **synchronous, active-high**.
- KEY  in  4  board push-buttons, active-low, asynchronous. KEY[0] = execute, KEY[1] = abort, KEY[3:2] unused.
- codop  in  4  opcode field.
- addA  in  4  source register A.
- addB_LMM  in  4  source register B, or immediate for LMM.
- addC  in  4  destination register.
- alu_done  in  1  ALU result valid, level, sampled in EXEC only.
- op_q, ra_q, rb_q, rc_q  out  4 each  latched instruction fields.
- rf_rd_en  out  1  register-file read strobe.
- alu_start  out  1  one-cycle ALU start pulse.
- imm_sel  out  1  write-back source is the immediate rb_q, not the ALU.
- rf_wr_en  out  1  register-file write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion, including NOP.
- instr_count  out  CNT_W  completed instructions, wraps to 0.

## Operation
- Each KEY[1:0] bit passes through a 2-flop synchronizer, then a debouncer. The debounced level flips only after DEBOUNCE_CYCLES consecutive identical samples that differ from the current level. A one-cycle press pulse fires on each debounced high→low transition of the raw key.
- Opcode classes (constants in package):
  - OP_NOP = 4'h0
  - OP_LMM = 4'h1
  - all others are ALU ops.
- FSM states and transitions:
  - IDLE: on exec pulse, latch codop/addA/addB_LMM/addC into op_q..rc_q, then go to DECODE.
  - DECODE: NOP → DONE; LMM → WRITE with imm_sel=1; ALU op → READ.
  - READ: rf_rd_en=1 for exactly one cycle, then go to EXEC.
  - EXEC: alu_start=1 in the first EXEC cycle only. Stay in EXEC until alu_done=1, then go to WRITE. No timeout.
  - WRITE: rf_wr_en=1 for one cycle. imm_sel holds its DECODE value. Then go to DONE.
  - DONE: done=1 for one cycle, instr_count+1, then go to IDLE.
- Exec pulses while busy are dropped, not queued.
- Abort pulse in any non-IDLE state forces IDLE next cycle:
  - rf_wr_en, alu_start and done stay 0 that cycle.
  - instr_count is unchanged.
  - latched fields are kept.
- Abort in IDLE is ignored.
- Abort and exec pulse in the same cycle while in IDLE: the exec wins.
- Switch inputs are sampled only at the latch edge; changes afterwards do not affect the running instruction.

## Timing
- Reset values:
  - state IDLE
  - all outputs 0 (op_q..rc_q, strobes, imm_sel, busy, done, instr_count)
  - debounced levels = released (1), synchronizers = 1
- Key latency: raw KEY fall → press pulse = 2 + DEBOUNCE_CYCLES cycles.
- Cycles from exec pulse (IDLE cycle) to the done pulse:
  - NOP: 2 cycles (DECODE, DONE).
  - LMM: 3 cycles (DECODE, WRITE, DONE).
  - ALU op: 4 + k cycles, where k ≥ 1 is the number of EXEC cycles up to and including the alu_done cycle.
- alu_done already high on the first EXEC cycle gives k=1: EXEC lasts one cycle with alu_start=1.
- rst mid-instruction returns everything to reset values on the next edge with no write strobe. A key held during rst must be re-released and re-pressed to produce a pulse.
- instr_count wraps from 2^CNT_W−1 to 0 with no flag.

## Structure
- Package seq_pkg: state enum (IDLE, DECODE, READ, EXEC, WRITE, DONE) and constants OP_NOP, OP_LMM.
- Sub-module key_debouncer (synchronizer + stable counter + fall-edge pulse, parameter DEBOUNCE_CYCLES), instantiated for KEY[0] and KEY[1].
- Top level holds the FSM, the field registers and the counter.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- Reset, then a KEY[0] press held for 3 cycles (bounce) → no pulse, busy stays 0. Held for 10 cycles → exactly one pulse, 6 cycles after the fall.
- Switches codop=1, addB_LMM=4'hA, addC=3, then press → rc_q=3, rb_q=A, imm_sel=1. rf_wr_en high 2 cycles after the pulse, done 1 cycle later, instr_count=1, rf_rd_en and alu_start never asserted.
- codop=5, alu_done raised 3 EXEC cycles after alu_start → rf_rd_en, alu_start, 3 EXEC cycles, rf_wr_en, done. Pulse-to-done = 7 cycles. Switches toggled mid-run leave op_q=5.
- codop=0 → done 2 cycles after the pulse, no strobes. A second exec press while busy is dropped: instr_count +1 only.
- ALU op with alu_done held low, then KEY[1] press → IDLE, no rf_wr_en or done, count unchanged. rst asserted in EXEC → all outputs 0 next edge.
- 256 NOPs with CNT_W=8 → instr_count returns to 0.
